dec_rr_scheduler: RTL and testbench
===================================

Name: dec_rr_scheduler

Overview:
- Round-robin scheduler that shares one ECC decoder instance (codeword in, mod in; info out, num_of_errors out) between NUM_REQ requesters.
- Accepts at most one codeword per cycle through per-requester valid/ready handshakes and drives the decoder inputs from a register stage.
- Tracks the requester tag through the decoder's fixed latency, routes each result back to its originator, and keeps saturating error-statistics counters.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MAX_CODEWORD_WIDTH, 32, codeword width.
- MAX_INFO_WIDTH, 26, decoded info width.
- DEC_LATENCY, 1, cycles from dec_data_in/dec_mod registered to dec_data_out/dec_num_of_errors valid (>=1).
- CNT_WIDTH, 16, statistics counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_data  in  NUM_REQ*MAX_CODEWORD_WIDTH  flattened codewords; requester i at slice i.
- req_mod  in  NUM_REQ*2  flattened mode per requester.
- dec_data_in  out  MAX_CODEWORD_WIDTH  to decoder.
- dec_mod  out  2  to decoder.
- dec_data_out  in  MAX_INFO_WIDTH  from decoder.
- dec_num_of_errors  in  2  from decoder.
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_data  out  MAX_INFO_WIDTH  decoded info, shared by all requesters.
- rsp_errors  out  2  num_of_errors for the response.
- stat_clr  in  1  synchronous clear of counters.
- cnt_single  out  CNT_WIDTH  responses with errors==1.
- cnt_double  out  CNT_WIDTH  responses with errors==2.
- busy  out  1  any request in flight.

Behaviour:
- Arbitration, combinational on req_valid and ptr:
  - Grant the first requesting index at or after ptr, wrapping modulo NUM_REQ.
  - req_ready[g]=1 only for the granted index; req_ready is all zero when no request is present.
  - Transfer occurs when req_valid[i]&&req_ready[i].
  - ptr <= g+1 (wraps to 0 after NUM_REQ-1) on a transfer; otherwise unchanged.
  - Reset ptr=0, giving requester 0 priority on the first cycle.
- No backpressure: the decoder is fully pipelined, so one transfer per cycle is sustained. Requesters must accept rsp unconditionally.
- Issue stage, on a transfer:
  - dec_data_in <= req_data slice, dec_mod <= req_mod slice, iss_tag <= g, iss_vld <= 1.
  - Otherwise iss_vld <= 0 and dec_data_in/dec_mod hold their values.
- Tag pipeline: shift register of DEC_LATENCY entries {vld, tag} fed by {iss_vld, iss_tag}.
- Response stage, when the tail entry is valid:
  - rsp_valid <= one-hot(tag), rsp_data <= dec_data_out, rsp_errors <= dec_num_of_errors.
  - Otherwise rsp_valid <= 0 and rsp_data/rsp_errors hold.
- Latency: transfer in cycle t gives rsp_valid high in cycle t+1+DEC_LATENCY for exactly one cycle. With the defaults this is t+2.
- Ordering: responses return strictly in accept order. Back-to-back accepts yield back-to-back responses.
- mod==2'b11 is accepted and forwarded unchanged; the response carries whatever the decoder returns (info 0).
- Counters, updated on each response:
  - cnt_single +1 when rsp_errors==1.
  - cnt_double +1 when rsp_errors==2.
  - Both saturate at all-ones.
  - stat_clr has priority over an increment in the same cycle: the result is 0 and that event is lost.
- busy = iss_vld | any tag-pipeline vld | any rsp_valid bit.
- Reset values, applied at the first clk edge with rst=1:
  - req_ready=0 (gated by rst).
  - dec_data_in=0, dec_mod=0, iss_vld=0.
  - All tag-pipeline vld=0, rsp_valid=0, rsp_data=0, rsp_errors=0.
  - cnt_*=0, ptr=0, busy=0.
- Reset mid-operation: in-flight requests are dropped with no response. After rst deasserts, the first response appears no earlier than 1+DEC_LATENCY cycles after the first new transfer.

Test Plan:
- Single request: req_valid=01, mod=00, clean 8-bit codeword for info 4'hA at cycle 0 -> req_ready=01 at cycle 0; rsp_valid=01, rsp_data=26'hA, rsp_errors=0 at cycle 2.
- Contention: both requesters hold valid for 6 cycles -> grants 0,1,0,1,0,1; six responses at cycles 2..7 with rsp_valid alternating 01,10; each rsp_data matches the sender's info.
- Fairness after idle: only requester 1 requests once (ptr becomes 0), then both request -> requester 0 is granted first.
- Error stats: send 3 codewords with one flipped bit and 2 with two flipped bits (mod=10) -> rsp_errors values 1,1,1,2,2; cnt_single=3, cnt_double=2.
- Counter boundaries: with CNT_WIDTH=4, drive 17 single-error responses -> cnt_single holds 4'hF. Assert stat_clr in the same cycle as a response with errors==1 -> counter reads 0 the next cycle.
- Reset mid-flight: accept a request at cycle 0, assert rst at cycle 1 -> no rsp_valid in cycles 1..4; busy=0 after the rst edge; all outputs at reset values.

Source files
------------

// File: rtl/dec_rr_scheduler.sv
// Round-robin front end that shares one pipelined ECC decoder between NUM_REQ requesters,
// tracks each requester's tag through the decoder latency and keeps error statistics.
module dec_rr_scheduler #(
  parameter int NUM_REQ            = 2,
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26,
  parameter int DEC_LATENCY        = 1,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ*MAX_CODEWORD_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]                  req_mod,
  output logic [MAX_CODEWORD_WIDTH-1:0]         dec_data_in,
  output logic [1:0]                            dec_mod,
  input  logic [MAX_INFO_WIDTH-1:0]             dec_data_out,
  input  logic [1:0]                            dec_num_of_errors,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [MAX_INFO_WIDTH-1:0]             rsp_data,
  output logic [1:0]                            rsp_errors,
  input  logic                                  stat_clr,
  output logic [CNT_WIDTH-1:0]                  cnt_single,
  output logic [CNT_WIDTH-1:0]                  cnt_double,
  output logic                                  busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic               xfer;

  // Stage 0 of the tag pipeline is the issue register itself, so the tail lines up
  // with the decoder output DEC_LATENCY cycles after dec_data_in is loaded.
  logic [DEC_LATENCY-1:0] pipe_vld;
  logic [PTR_W-1:0]       pipe_tag [DEC_LATENCY];
  logic                   tail_vld;
  logic [PTR_W-1:0]       tail_tag;
  logic                   rsp_fire;

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  always_comb begin
    grant_idx = ptr;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req_valid[wrap_idx(ptr, i)]) begin
        grant_any = 1'b1;
        grant_idx = wrap_idx(ptr, i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_any && !rst) req_ready[grant_idx] = 1'b1;
  end

  assign xfer     = |(req_valid & req_ready);
  assign tail_vld = pipe_vld[DEC_LATENCY-1];
  assign tail_tag = pipe_tag[DEC_LATENCY-1];
  assign rsp_fire = |rsp_valid;
  assign busy     = (|pipe_vld) | rsp_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (xfer) begin
      if (int'(grant_idx) == NUM_REQ - 1) ptr <= '0;
      else                                ptr <= grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_data_in <= '0;
      dec_mod     <= '0;
      pipe_vld    <= '0;
      for (int s = 0; s < DEC_LATENCY; s++) pipe_tag[s] <= '0;
    end else begin
      pipe_vld[0] <= xfer;
      if (xfer) begin
        pipe_tag[0] <= grant_idx;
        dec_data_in <= req_data[grant_idx*MAX_CODEWORD_WIDTH +: MAX_CODEWORD_WIDTH];
        dec_mod     <= req_mod[grant_idx*2 +: 2];
      end
      for (int s = 1; s < DEC_LATENCY; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_tag[s] <= pipe_tag[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_errors <= '0;
    end else begin
      rsp_valid <= tail_vld ? (NUM_REQ'(1) << tail_tag) : '0;
      if (tail_vld) begin
        rsp_data   <= dec_data_out;
        rsp_errors <= dec_num_of_errors;
      end
    end
  end

  // Clear wins over a same-cycle increment; that response is simply not counted.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (rsp_fire) begin
      if (rsp_errors == 2'd1 && cnt_single != '1) cnt_single <= cnt_single + 1'b1;
      if (rsp_errors == 2'd2 && cnt_double != '1) cnt_double <= cnt_double + 1'b1;
    end
  end

endmodule

// File: tb/tb_dec_rr_scheduler.sv
// Directed bench for dec_rr_scheduler: two instances (16-bit and 4-bit counters) share the
// request stimulus; a stub decoder passes info bits through and reports errors from cw[31:30].
module tb_dec_rr_scheduler;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_mod;
  logic        stat_clr;

  logic [1:0]  req_ready, rsp_valid, rsp_errors, dec_mod, dec_num_of_errors;
  logic [31:0] dec_data_in;
  logic [25:0] dec_data_out, rsp_data;
  logic [15:0] cnt_single, cnt_double;
  logic        busy;

  logic [1:0]  req_ready_4, rsp_valid_4, rsp_errors_4, dec_mod_4, dec_num_of_errors_4;
  logic [31:0] dec_data_in_4;
  logic [25:0] dec_data_out_4, rsp_data_4;
  logic [3:0]  cnt_single_4, cnt_double_4;
  logic        busy_4;

  int check_count = 0;
  int error_count = 0;

  logic [31:0] err_cw  [5] = '{32'h4000_0011, 32'h4000_0012, 32'h4000_0013, 32'h8000_0014, 32'h8000_0015};
  logic [1:0]  err_exp [5] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2};

  // Stub decoder: output valid in the cycle after dec_data_in is loaded (DEC_LATENCY=1).
  function automatic logic [25:0] stub_info(input logic [31:0] cw, input logic [1:0] m);
    return (m == 2'b11) ? 26'h0 : cw[25:0];
  endfunction

  assign dec_data_out        = stub_info(dec_data_in, dec_mod);
  assign dec_num_of_errors   = dec_data_in[31:30];
  assign dec_data_out_4      = stub_info(dec_data_in_4, dec_mod_4);
  assign dec_num_of_errors_4 = dec_data_in_4[31:30];

  dec_rr_scheduler #(.NUM_REQ(2), .MAX_CODEWORD_WIDTH(32), .MAX_INFO_WIDTH(26),
                     .DEC_LATENCY(1), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_mod(req_mod), .dec_data_in(dec_data_in), .dec_mod(dec_mod),
    .dec_data_out(dec_data_out), .dec_num_of_errors(dec_num_of_errors),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_errors(rsp_errors),
    .stat_clr(stat_clr), .cnt_single(cnt_single), .cnt_double(cnt_double), .busy(busy)
  );

  dec_rr_scheduler #(.NUM_REQ(2), .MAX_CODEWORD_WIDTH(32), .MAX_INFO_WIDTH(26),
                     .DEC_LATENCY(1), .CNT_WIDTH(4)) u_dut_4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_4),
    .req_data(req_data), .req_mod(req_mod), .dec_data_in(dec_data_in_4), .dec_mod(dec_mod_4),
    .dec_data_out(dec_data_out_4), .dec_num_of_errors(dec_num_of_errors_4),
    .rsp_valid(rsp_valid_4), .rsp_data(rsp_data_4), .rsp_errors(rsp_errors_4),
    .stat_clr(stat_clr), .cnt_single(cnt_single_4), .cnt_double(cnt_double_4), .busy(busy_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] d0, input logic [1:0] m0,
                               input logic [31:0] d1, input logic [1:0] m1);
    req_valid = v;
    req_data  = {d1, d0};
    req_mod   = {m1, m0};
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    stat_clr = 1'b0;
    applyStimulus(2'b00, 32'h0, 2'b00, 32'h0, 2'b00);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("reset_ready", req_ready, 2'b00);
    checkOutput("reset_rsp_valid", rsp_valid, 2'b00);
    checkOutput("reset_dec_data_in", dec_data_in, 32'h0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_cnt_single", cnt_single, 16'h0);
    checkOutput("reset_cnt_double", cnt_double, 16'h0);
    rst = 1'b0;
    nextCycle();

    // Single request from requester 0, response two cycles later
    applyStimulus(2'b01, 32'h0000_000A, 2'b00, 32'h0, 2'b00);
    @(negedge clk);
    checkOutput("single_ready", req_ready, 2'b01);
    nextCycle();
    applyStimulus(2'b00, 32'h0, 2'b00, 32'h0, 2'b00);
    @(negedge clk);
    checkOutput("single_rsp_early", rsp_valid, 2'b00);
    checkOutput("single_busy_issue", busy, 1'b1);
    nextCycle();
    @(negedge clk);
    checkOutput("single_rsp_valid", rsp_valid, 2'b01);
    checkOutput("single_rsp_data", rsp_data, 26'hA);
    checkOutput("single_rsp_errors", rsp_errors, 2'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("single_rsp_pulse", rsp_valid, 2'b00);
    checkOutput("single_busy_idle", busy, 1'b0);
    nextCycle();

    // Reset while a request is in flight
    applyStimulus(2'b01, 32'h4000_0055, 2'b01, 32'h0, 2'b00);
    @(negedge clk);
    checkOutput("midrst_accept", req_ready, 2'b01);
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ready_gated", req_ready, 2'b00);
    checkOutput("midrst_rsp_c1", rsp_valid, 2'b00);
    nextCycle();
    rst = 1'b0;
    applyStimulus(2'b00, 32'h0, 2'b00, 32'h0, 2'b00);
    @(negedge clk);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_dec_data_in", dec_data_in, 32'h0);
    checkOutput("midrst_dec_mod", dec_mod, 2'b00);
    checkOutput("midrst_rsp_data", rsp_data, 26'h0);
    checkOutput("midrst_rsp_errors", rsp_errors, 2'd0);
    for (int c = 2; c <= 4; c++) begin
      if (c > 2) @(negedge clk);
      checkOutput($sformatf("midrst_rsp_c%0d", c), rsp_valid, 2'b00);
      nextCycle();
    end

    // Contention: both requesters valid for 6 cycles, pointer is 0 after reset
    for (int k = 0; k < 8; k++) begin
      if (k < 6) applyStimulus(2'b11, 32'h100 + k, 2'b00, 32'h200 + k, 2'b00);
      else       applyStimulus(2'b00, 32'h0, 2'b00, 32'h0, 2'b00);
      @(negedge clk);
      if (k < 6) checkOutput($sformatf("cont_ready_%0d", k), req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k >= 2) begin
        checkOutput($sformatf("cont_rsp_valid_%0d", k), rsp_valid, ((k - 2) % 2 == 0) ? 2'b01 : 2'b10);
        checkOutput($sformatf("cont_rsp_data_%0d", k), rsp_data,
                    ((k - 2) % 2 == 0) ? 32'h100 + k - 2 : 32'h200 + k - 2);
      end
      nextCycle();
    end

    // Fairness after idle: lone grant to requester 1 wraps pointer to 0
    applyStimulus(2'b10, 32'h0, 2'b00, 32'h301, 2'b00);
    @(negedge clk);
    checkOutput("fair_lone", req_ready, 2'b10);
    nextCycle();
    applyStimulus(2'b11, 32'h310, 2'b00, 32'h311, 2'b00);
    @(negedge clk);
    checkOutput("fair_first", req_ready, 2'b01);
    nextCycle();
    applyStimulus(2'b01, 32'h0000_00FF, 2'b11, 32'h0, 2'b00);
    @(negedge clk);
    checkOutput("fair_rsp1_valid", rsp_valid, 2'b10);
    checkOutput("fair_rsp1_data", rsp_data, 26'h301);
    nextCycle();
    applyStimulus(2'b00, 32'h0, 2'b00, 32'h0, 2'b00);
    @(negedge clk);
    checkOutput("fair_rsp0_valid", rsp_valid, 2'b01);
    checkOutput("fair_rsp0_data", rsp_data, 26'h310);
    checkOutput("mod11_forward", dec_mod, 2'b11);
    nextCycle();
    @(negedge clk);
    checkOutput("mod11_rsp_valid", rsp_valid, 2'b01);
    checkOutput("mod11_rsp_data", rsp_data, 26'h0);
    nextCycle();

    // Error statistics: three single-error and two double-error words
    stat_clr = 1'b1;
    nextCycle();
    stat_clr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k < 5) applyStimulus(2'b01, err_cw[k], 2'b10, 32'h0, 2'b00);
      else       applyStimulus(2'b00, 32'h0, 2'b00, 32'h0, 2'b00);
      @(negedge clk);
      if (k >= 2 && k < 7) begin
        checkOutput($sformatf("err_rsp_valid_%0d", k), rsp_valid, 2'b01);
        checkOutput($sformatf("err_rsp_errors_%0d", k), rsp_errors, err_exp[k-2]);
        checkOutput($sformatf("err_rsp_data_%0d", k), rsp_data, 32'h11 + k - 2);
      end
      nextCycle();
    end
    @(negedge clk);
    checkOutput("err_cnt_single", cnt_single, 16'd3);
    checkOutput("err_cnt_double", cnt_double, 16'd2);
    checkOutput("err_cnt_single_4", cnt_single_4, 4'd3);
    nextCycle();

    // Saturation: 17 single-error responses into the 4-bit counters
    stat_clr = 1'b1;
    nextCycle();
    stat_clr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k < 17) applyStimulus(2'b01, 32'h4000_0000 | k, 2'b00, 32'h0, 2'b00);
      else        applyStimulus(2'b00, 32'h0, 2'b00, 32'h0, 2'b00);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("sat_cnt_single_16", cnt_single, 16'd17);
    checkOutput("sat_cnt_single_4", cnt_single_4, 4'hF);
    checkOutput("sat_cnt_double_4", cnt_double_4, 4'h0);
    nextCycle();

    // Clear in the same cycle as a single-error response
    applyStimulus(2'b01, 32'h4000_0001, 2'b00, 32'h0, 2'b00);
    nextCycle();
    applyStimulus(2'b00, 32'h0, 2'b00, 32'h0, 2'b00);
    nextCycle();
    stat_clr = 1'b1;
    @(negedge clk);
    checkOutput("clr_rsp_valid", rsp_valid, 2'b01);
    checkOutput("clr_rsp_errors", rsp_errors, 2'd1);
    nextCycle();
    stat_clr = 1'b0;
    @(negedge clk);
    checkOutput("clr_cnt_single_16", cnt_single, 16'd0);
    checkOutput("clr_cnt_single_4", cnt_single_4, 4'd0);
    checkOutput("clr_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
